// File: rtl/hazard_stall_unit.sv
// Hazard controller: load-use stalls, taken-branch flushes and memory freeze.
// Tracks freeze duration with a sticky timeout and saturating statistics.
module hazard_stall_unit #(
  parameter int REG_W    = 5,
  parameter int CNT_W    = 16,
  parameter int MAX_WAIT = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] IF_ID_rs1,
  input  logic [REG_W-1:0] IF_ID_rs2,
  input  logic             IF_ID_uses_rs1,
  input  logic             IF_ID_uses_rs2,
  input  logic [REG_W-1:0] ID_EX_rd,
  input  logic             ID_EX_mem_read,
  input  logic             EX_MEM_mem_req,
  input  logic             mem_ready,
  input  logic             branch_taken,
  output logic             pc_write,
  output logic             IF_ID_write,
  output logic             IF_ID_flush,
  output logic             ID_EX_bubble,
  output logic             pipe_freeze,
  output logic             mem_wait,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  localparam int WC_W = $clog2(MAX_WAIT + 1);

  typedef enum logic {
    RUN  = 1'b0,
    WAIT = 1'b1
  } state_t;

  state_t            state;
  state_t            next_state;
  logic [WC_W-1:0]   wait_cnt;
  logic              load_use;
  logic              hit_rs1;
  logic              hit_rs2;

  assign hit_rs1 = IF_ID_uses_rs1 && (ID_EX_rd == IF_ID_rs1);
  assign hit_rs2 = IF_ID_uses_rs2 && (ID_EX_rd == IF_ID_rs2);
  assign load_use = ID_EX_mem_read && (ID_EX_rd != '0)
                    && (hit_rs1 || hit_rs2);

  assign pipe_freeze = !rst && EX_MEM_mem_req && !mem_ready;

  // Overlapping causes resolve by priority, so this is not a unique case.
  always_comb begin
    pc_write     = 1'b1;
    IF_ID_write  = 1'b1;
    IF_ID_flush  = 1'b0;
    ID_EX_bubble = 1'b0;
    priority case (1'b1)
      rst: begin
        pc_write     = 1'b0;
        IF_ID_write  = 1'b0;
        IF_ID_flush  = 1'b1;
        ID_EX_bubble = 1'b1;
      end
      pipe_freeze: begin
        pc_write    = 1'b1;
        IF_ID_write = 1'b1;
      end
      branch_taken: begin
        IF_ID_flush  = 1'b1;
        ID_EX_bubble = 1'b1;
      end
      load_use: begin
        pc_write     = 1'b0;
        IF_ID_write  = 1'b0;
        ID_EX_bubble = 1'b1;
      end
      default: begin
        pc_write    = 1'b1;
        IF_ID_write = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= RUN;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      RUN:     next_state = pipe_freeze ? WAIT : RUN;
      WAIT:    next_state = pipe_freeze ? WAIT : RUN;
      default: next_state = RUN;
    endcase
  end

  always_comb begin
    mem_wait = (state == WAIT);
  end

  // Timeout fires on the edge closing the MAX_WAIT-th frozen cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt    <= '0;
      mem_timeout <= 1'b0;
    end else if (pipe_freeze) begin
      if (wait_cnt != WC_W'(MAX_WAIT))
        wait_cnt <= wait_cnt + 1'b1;
      if (wait_cnt == WC_W'(MAX_WAIT - 1))
        mem_timeout <= 1'b1;
    end else begin
      wait_cnt <= '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      if (!pc_write && stall_cycles != '1)
        stall_cycles <= stall_cycles + 1'b1;
      if (IF_ID_flush && flush_count != '1)
        flush_count <= flush_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Bench for hazard_stall_unit: vector table, corner sequences, random vs model.
// Uses a 4-bit counter width so saturation is reachable quickly.
module tb_hazard_stall_unit;

  localparam int REG_W    = 5;
  localparam int CNT_W    = 4;
  localparam int MAX_WAIT = 8;
  localparam int CMAX     = (1 << CNT_W) - 1;

  logic             clk;
  logic             rst;
  logic [REG_W-1:0] rs1, rs2, rd;
  logic             u1, u2, mr, req, rdy, br;
  logic             pc_write, IF_ID_write, IF_ID_flush, ID_EX_bubble;
  logic             pipe_freeze, mem_wait, mem_timeout;
  logic [CNT_W-1:0] stall_cycles, flush_count;
  logic [4:0]       dut_comb;

  hazard_stall_unit #(
    .REG_W(REG_W), .CNT_W(CNT_W), .MAX_WAIT(MAX_WAIT)
  ) dut (
    .clk(clk), .rst(rst),
    .IF_ID_rs1(rs1), .IF_ID_rs2(rs2),
    .IF_ID_uses_rs1(u1), .IF_ID_uses_rs2(u2),
    .ID_EX_rd(rd), .ID_EX_mem_read(mr),
    .EX_MEM_mem_req(req), .mem_ready(rdy),
    .branch_taken(br),
    .pc_write(pc_write), .IF_ID_write(IF_ID_write),
    .IF_ID_flush(IF_ID_flush), .ID_EX_bubble(ID_EX_bubble),
    .pipe_freeze(pipe_freeze), .mem_wait(mem_wait),
    .mem_timeout(mem_timeout),
    .stall_cycles(stall_cycles), .flush_count(flush_count)
  );

  assign dut_comb = {pc_write, IF_ID_write, IF_ID_flush,
                     ID_EX_bubble, pipe_freeze};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference state: plain integers, unbounded run length.
  int run_len   = 0;
  int n_stall   = 0;
  int n_flush   = 0;
  bit m_timeout = 0;
  bit m_wait    = 0;

  typedef struct {
    logic [4:0] rs1, rs2, rd;
    logic       u1, u2, mr, req, rdy, br;
    logic [4:0] exp;
  } vec_t;

  vec_t tbl[11];

  function automatic logic [4:0] model_comb();
    bit lu;
    lu = mr && (rd != 0) && ((u1 && rd == rs1) || (u2 && rd == rs2));
    if (rst)             return 5'b00110;
    if (req && !rdy)     return 5'b11001;
    if (br)              return 5'b11110;
    if (lu)              return 5'b00010;
    return 5'b11000;
  endfunction

  task automatic model_tick();
    logic [4:0] c;
    c = model_comb();
    if (rst) begin
      run_len = 0; n_stall = 0; n_flush = 0;
      m_timeout = 0; m_wait = 0;
    end else begin
      m_wait  = c[0];
      run_len = c[0] ? run_len + 1 : 0;
      if (run_len >= MAX_WAIT) m_timeout = 1;
      if (!c[4] && n_stall < CMAX) n_stall++;
      if (c[2] && n_flush < CMAX) n_flush++;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_in(input logic [4:0] a, input logic [4:0] b,
                        input logic a_u, input logic b_u,
                        input logic [4:0] d, input logic m,
                        input logic q, input logic y, input logic t);
    rs1 = a; rs2 = b; u1 = a_u; u2 = b_u; rd = d;
    mr = m; req = q; rdy = y; br = t;
  endtask

  // Called at a negedge with inputs applied; leaves at the next negedge.
  task automatic step(input string name, input bit use_exp,
                      input logic [4:0] exp);
    logic [4:0] e;
    #1;
    e = use_exp ? exp : model_comb();
    check({name, " comb"}, 32'(dut_comb), 32'(e));
    @(posedge clk);
    model_tick();
    #1;
    check({name, " regs"},
          32'({mem_wait, mem_timeout, stall_cycles, flush_count}),
          32'({m_wait, m_timeout, CNT_W'(n_stall), CNT_W'(n_flush)}));
    @(negedge clk);
  endtask

  initial begin
    tbl[0]  = '{5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'b11000};
    tbl[1]  = '{5'd1, 5'd5, 5'd5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'b00010};
    tbl[2]  = '{5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'b11000};
    tbl[3]  = '{5'd1, 5'd5, 5'd5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'b11000};
    tbl[4]  = '{5'd7, 5'd2, 5'd7, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'b00010};
    tbl[5]  = '{5'd7, 5'd2, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'b11000};
    tbl[6]  = '{5'd1, 5'd5, 5'd5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 5'b11110};
    tbl[7]  = '{5'd1, 5'd5, 5'd5, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 5'b11001};
    tbl[8]  = '{5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 5'b11110};
    tbl[9]  = '{5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'b11000};
    tbl[10] = '{5'd31, 5'd3, 5'd31, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'b00010};

    rst = 1'b1;
    set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    step("reset", 1, 5'b00110);
    rst = 1'b0;
    set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    step("idle", 1, 5'b11000);

    foreach (tbl[i]) begin
      set_in(tbl[i].rs1, tbl[i].rs2, tbl[i].u1, tbl[i].u2, tbl[i].rd,
             tbl[i].mr, tbl[i].req, tbl[i].rdy, tbl[i].br);
      step($sformatf("vec%0d", i), 1, tbl[i].exp);
    end

    // Short freeze: three frozen cycles then memory answers.
    set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step("freeze3", 1, 5'b11001);
    rdy = 1'b1;
    step("freeze3 end", 1, 5'b11000);
    check("freeze3 no timeout", 32'(mem_timeout), 32'd0);
    check("freeze3 run", 32'(mem_wait), 32'd0);

    // Freeze interrupted by reset never reaches the timeout.
    rdy = 1'b0;
    for (int i = 0; i < 3; i++) step("frz rst pre", 1, 5'b11001);
    rst = 1'b1;
    step("frz rst", 1, 5'b00110);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) step("frz rst post", 1, 5'b11001);
    rdy = 1'b1;
    step("frz rst end", 1, 5'b11000);
    check("rst no timeout", 32'(mem_timeout), 32'd0);

    // Full MAX_WAIT freeze sets the sticky timeout.
    rdy = 1'b0;
    for (int i = 0; i < MAX_WAIT; i++) step("freeze8", 1, 5'b11001);
    check("freeze8 timeout", 32'(mem_timeout), 32'd1);
    rdy = 1'b1;
    step("freeze8 end", 1, 5'b11000);
    step("freeze8 after", 1, 5'b11000);
    check("timeout sticky", 32'(mem_timeout), 32'd1);

    rst = 1'b1;
    step("reset2", 1, 5'b00110);
    rst = 1'b0;
    check("timeout cleared", 32'(mem_timeout), 32'd0);

    // Twenty single-cycle load-use stalls saturate the 4-bit counter.
    for (int i = 0; i < 20; i++) begin
      set_in(5'd0, 5'd9, 1'b0, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0);
      step("lu stall", 1, 5'b00010);
      mr = 1'b0;
      step("lu release", 1, 5'b11000);
    end
    check("stall saturated", 32'(stall_cycles), 32'd15);
    check("no flush", 32'(flush_count), 32'd0);

    for (int i = 0; i < 2000; i++) begin
      rst = ($urandom_range(0, 199) == 0);
      set_in(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
             1'($urandom), 1'($urandom), 5'($urandom_range(0, 3)),
             1'($urandom), ($urandom_range(0, 9) < 7),
             ($urandom_range(0, 4) == 0), ($urandom_range(0, 5) == 0));
      step("rand", 0, 5'b00000);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
